bsg_nand_sliced: RTL and testbench

- Multi-cycle, area-reduced bitwise NAND engine for wide operands.
- Accepts a width_p-bit operand pair on a ready/valid input.
- Computes o = ~(a & b) one slice_width_p-bit slice per cycle, using a single slice-wide NAND array.
- Presents the full result on a valid/yumi output.
- Sits in bsg_misc as the sequential, handshaked counterpart of the flat combinational NAND, for datapaths that trade latency for gate count.

---
 rtl/bsg_nand_sliced.sv | 81 ++++++++
 tb/tb_bsg_nand_sliced.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nand_sliced.sv
// Multi-cycle bitwise NAND: one slice_width_p-bit slice of ~(a & b) per cycle,
// with a ready/valid operand input and a valid/yumi result output.
module bsg_nand_sliced #(
  parameter int width_p       = 64,
  parameter int slice_width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int els_lp       = width_p / slice_width_p;
  localparam int cnt_width_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(els_lp - 1);

  if ((slice_width_p < 1) || (slice_width_p > width_p) || ((width_p % slice_width_p) != 0)) begin : g_param_check
    $error("bsg_nand_sliced: slice_width_p must divide width_p and lie in 1..width_p");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e state_r, state_n;

  // Operands and result viewed as slice arrays so the counter indexes them directly
  logic [els_lp-1:0][slice_width_p-1:0] a_r, b_r, data_r;
  logic [cnt_width_lp-1:0]              cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:    if (v_i)                  state_n = BUSY;
      BUSY:    if (cnt_r == last_cnt_lp) state_n = DONE;
      DONE:    if (yumi_i)               state_n = IDLE;
      default:                           state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_r    <= '0;
      b_r    <= '0;
      data_r <= '0;
      cnt_r  <= '0;
    end else begin
      unique case (state_r)
        IDLE: begin
          if (v_i) begin
            a_r    <= a_i;
            b_r    <= b_i;
            data_r <= '0;
            cnt_r  <= '0;
          end
        end
        BUSY: begin
          // The single slice-wide NAND array, steered by the slice counter
          data_r[cnt_r] <= ~(a_r[cnt_r] & b_r[cnt_r]);
          if (cnt_r != last_cnt_lp) cnt_r <= cnt_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (state_r == IDLE);
  assign v_o     = (state_r == DONE);
  assign data_o  = data_r;

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_nand_sliced.sv
// Directed bench for bsg_nand_sliced: default 64/16 instance plus a
// slice-width sweep (1, 8, 64) running in parallel on the same clock.
module tb_bsg_nand_sliced;

  logic        clk;
  logic        reset_n;
  logic        v_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        yumi_i;
  logic        ready_o;
  logic        v_o;
  logic [63:0] data_o;

  logic        sw_v;
  logic [63:0] sw_a;
  logic [63:0] sw_b;
  logic [2:0]  sw_ready;
  logic [2:0]  sw_vo;
  logic [2:0]  sw_yumi;
  logic [63:0] sw_data [3];

  int total = 0;
  int bad   = 0;

  bsg_nand_sliced #(.width_p(64), .slice_width_p(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .a_i(a_i), .b_i(b_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  bsg_nand_sliced #(.width_p(64), .slice_width_p(1)) dut_s1 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(sw_v), .a_i(sw_a), .b_i(sw_b),
    .ready_o(sw_ready[0]), .v_o(sw_vo[0]), .data_o(sw_data[0]), .yumi_i(sw_yumi[0])
  );

  bsg_nand_sliced #(.width_p(64), .slice_width_p(8)) dut_s8 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(sw_v), .a_i(sw_a), .b_i(sw_b),
    .ready_o(sw_ready[1]), .v_o(sw_vo[1]), .data_o(sw_data[1]), .yumi_i(sw_yumi[1])
  );

  bsg_nand_sliced #(.width_p(64), .slice_width_p(64)) dut_s64 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(sw_v), .a_i(sw_a), .b_i(sw_b),
    .ready_o(sw_ready[2]), .v_o(sw_vo[2]), .data_o(sw_data[2]), .yumi_i(sw_yumi[2])
  );

  // Sweep instances consume their result the moment it appears
  assign sw_yumi = sw_vo;

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Result with only the lowest k 16-bit slices written, the rest still zero
  function automatic logic [63:0] partial(input logic [63:0] full, input int k);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = (i < 16 * k) ? full[i] : 1'b0;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation on the 64/16 instance; entered and left 1 time unit after an edge in IDLE
  task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] exp, input int hold);
    logic [63:0] held;
    check_output("idle_ready", {63'd0, ready_o}, 64'd1);
    v_i = 1'b1;
    a_i = a;
    b_i = b;
    step();
    v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_output("busy_ready", {63'd0, ready_o}, 64'd0);
      check_output("busy_v", {63'd0, v_o}, 64'd0);
      check_output("busy_data", data_o, partial(exp, k));
      step();
    end
    check_output("done_v", {63'd0, v_o}, 64'd1);
    check_output("done_data", data_o, exp);
    held = exp;
    for (int h = 0; h < hold; h++) begin
      v_i = 1'($urandom_range(0, 1));
      a_i = {$urandom, $urandom};
      b_i = {$urandom, $urandom};
      step();
      check_output("hold_v", {63'd0, v_o}, 64'd1);
      check_output("hold_ready", {63'd0, ready_o}, 64'd0);
      check_output("hold_data", data_o, held);
    end
    v_i    = 1'b0;
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    check_output("after_yumi_ready", {63'd0, ready_o}, 64'd1);
    check_output("after_yumi_v", {63'd0, v_o}, 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [63:0] exp_q[$];
    int          got_n, last_t;
    int          lat[3];
    int          els[3];

    clk = 1'b0; reset_n = 1'b0; v_i = 1'b0; a_i = '0; b_i = '0; yumi_i = 1'b0;
    sw_v = 1'b0; sw_a = '0; sw_b = '0;
    els[0] = 64; els[1] = 8; els[2] = 1;

    #12;
    check_output("reset_ready", {63'd0, ready_o}, 64'd1);
    check_output("reset_v", {63'd0, v_o}, 64'd0);
    check_output("reset_data", data_o, 64'd0);
    check_output("reset_sweep_ready", {61'd0, sw_ready}, 64'd7);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    $display("[TB] single op");
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 0);

    $display("[TB] slice ordering");
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 0);
    apply_stimulus(64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    apply_stimulus(64'h1234_5678_9ABC_DEF0, 64'hFF00_FF00_00FF_00FF, 64'hEDFF_A9FF_FF43_FF0F, 0);

    $display("[TB] backpressure");
    apply_stimulus(64'hA5A5_0000_FFFF_3C3C, 64'hFFFF_FFFF_0F0F_F0F0, 64'h5A5A_FFFF_F0F0_CFCF, 10);
    apply_stimulus(64'h8000_0000_0000_0001, 64'hC000_0000_0000_0003, 64'h7FFF_FFFF_FFFF_FFFE, 0);

    $display("[TB] back-to-back");
    got_n  = 0;
    last_t = -1;
    v_i    = 1'b1;
    for (int t = 0; t < 40 && got_n < 3; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (ready_o) exp_q.push_back(~(ra & rb));
      a_i = ra;
      b_i = rb;
      yumi_i = v_o;
      if (v_o) begin
        if (exp_q.size() > 0) check_output("b2b_data", data_o, exp_q.pop_front());
        else check_output("b2b_queue", 64'd0, 64'd1);
        if (last_t >= 0) check_output("b2b_spacing", 64'(t - last_t), 64'd6);
        last_t = t;
        got_n++;
        if (got_n == 3) v_i = 1'b0;
      end
      step();
    end
    v_i    = 1'b0;
    yumi_i = 1'b0;
    check_output("b2b_count", 64'(got_n), 64'd3);
    check_output("b2b_idle_ready", {63'd0, ready_o}, 64'd1);

    $display("[TB] async reset mid-busy");
    v_i = 1'b1;
    a_i = 64'hFFFF_FFFF_FFFF_FFFF;
    b_i = 64'hFFFF_0000_FFFF_0000;
    step();
    v_i = 1'b0;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check_output("rst_mid_v", {63'd0, v_o}, 64'd0);
    check_output("rst_mid_data", data_o, 64'd0);
    check_output("rst_mid_ready", {63'd0, ready_o}, 64'd1);
    step();
    reset_n = 1'b1;
    step();
    apply_stimulus(64'h0F0F_F0F0_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hF0F0_0F0F_FFFF_0000, 0);

    $display("[TB] slice width sweep");
    for (int op = 0; op < 2; op++) begin
      sw_a = {$urandom, $urandom};
      sw_b = {$urandom, $urandom};
      sw_v = 1'b1;
      step();
      sw_v = 1'b0;
      for (int j = 0; j < 3; j++) lat[j] = 0;
      for (int n = 1; n <= 70; n++) begin
        step();
        for (int j = 0; j < 3; j++) begin
          if (sw_vo[j] && lat[j] == 0) begin
            lat[j] = n;
            check_output("sweep_data", sw_data[j], ~(sw_a & sw_b));
          end
        end
      end
      for (int j = 0; j < 3; j++) check_output("sweep_latency", 64'(lat[j]), 64'(els[j]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
